// File: rtl/ram_access_arbiter.sv
// +----------------------------------------------------------------------------+
// | ram_access_arbiter: round-robin, transaction-atomic sharing of one RAM     |
// | command port between two requesters, with read-data return routing.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_access_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] r0_din,
  input  logic                 r0_valid,
  output logic                 r0_ready,
  output logic [ADDR_SIZE-1:0] r0_dout,
  output logic                 r0_tx_valid,
  input  logic [ADDR_SIZE+1:0] r1_din,
  input  logic                 r1_valid,
  output logic                 r1_ready,
  output logic [ADDR_SIZE-1:0] r1_dout,
  output logic                 r1_tx_valid,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 timeout_err
);

  localparam int CW = ADDR_SIZE + 2;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK    = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t          r_state, w_state_nx;
  logic            r_owner, w_owner_nx;
  logic            r_ptr, w_ptr_nx;
  logic [TW-1:0]   r_cnt, w_cnt_nx, w_cnt_inc;
  logic            w_winner, w_sel, w_acc, w_expire, w_tmo, w_route;
  logic [CW-1:0]   w_word;
  logic [1:0]      w_op;

  // Grant logic: in IDLE the winner is the pointer's favourite when both ask.
  always_comb begin
    w_winner = (r0_valid && r1_valid) ? r_ptr : !r0_valid;
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    case (r_state)
      IDLE: begin
        r0_ready = r0_valid && !w_winner;
        r1_ready = r1_valid &&  w_winner;
      end
      LOCK: begin
        r0_ready = r0_valid && !r_owner;
        r1_ready = r1_valid &&  r_owner;
      end
      default: ;
    endcase
    w_acc  = (r0_valid && r0_ready) || (r1_valid && r1_ready);
    w_word = r1_ready ? r1_din : r0_din;
    w_op   = w_word[CW-1 -: 2];
    w_sel  = (r_state == IDLE) ? w_winner : r_owner;
  end

  assign w_cnt_inc = r_cnt + TW'(1);
  assign w_expire  = (w_cnt_inc == TW'(TIMEOUT));

  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    w_tmo      = 1'b0;
    w_route    = 1'b0;
    case (r_state)
      IDLE, LOCK: begin
        if (w_acc) begin
          w_owner_nx = w_sel;
          w_cnt_nx   = '0;
          case (w_op)
            2'b01: begin
              w_state_nx = IDLE;
              w_ptr_nx   = !w_sel;
            end
            2'b11:   w_state_nx = WAIT_RD;
            default: w_state_nx = LOCK;
          endcase
        end else if (r_state == LOCK) begin
          if (w_expire) begin
            w_state_nx = IDLE;
            w_tmo      = 1'b1;
            w_ptr_nx   = !r_owner;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
      end
      WAIT_RD: begin
        // Returning data takes precedence over a coincident expiry.
        if (ram_tx_valid) begin
          w_route    = 1'b1;
          w_state_nx = IDLE;
          w_ptr_nx   = !r_owner;
          w_cnt_nx   = '0;
        end else if (w_expire) begin
          w_state_nx = IDLE;
          w_tmo      = 1'b1;
          w_ptr_nx   = !r_owner;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_ptr        <= 1'b0;
      r_cnt        <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      r0_dout      <= '0;
      r1_dout      <= '0;
      r0_tx_valid  <= 1'b0;
      r1_tx_valid  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_owner      <= w_owner_nx;
      r_ptr        <= w_ptr_nx;
      r_cnt        <= w_cnt_nx;
      ram_rx_valid <= w_acc;
      if (w_acc) ram_din <= w_word;
      r0_tx_valid  <= w_route && !r_owner;
      r1_tx_valid  <= w_route &&  r_owner;
      if (w_route && !r_owner) r0_dout <= ram_dout;
      if (w_route &&  r_owner) r1_dout <= ram_dout;
      timeout_err  <= w_tmo;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_ram_access_arbiter: directed self-checking bench for ram_access_arbiter |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ram_access_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] r0_din = '0, r1_din = '0;
  logic       r0_valid = 1'b0, r1_valid = 1'b0;
  logic       r0_ready, r1_ready, r0_tx_valid, r1_tx_valid;
  logic [7:0] r0_dout, r1_dout;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout = '0;
  logic       ram_tx_valid = 1'b0;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  bit watch_r1 = 1'b0, r1_seen = 1'b0;
  bit early;

  ram_access_arbiter #(.ADDR_SIZE(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_din(r0_din), .r0_valid(r0_valid), .r0_ready(r0_ready),
    .r0_dout(r0_dout), .r0_tx_valid(r0_tx_valid),
    .r1_din(r1_din), .r1_valid(r1_valid), .r1_ready(r1_ready),
    .r1_dout(r1_dout), .r1_tx_valid(r1_tx_valid),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (watch_r1 && r1_ready) r1_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a word, wait (bounded) for its grant, check the RAM strobe after the edge.
  task automatic send(input bit req, input logic [9:0] w);
    bit done = 1'b0;
    if (req) begin r1_din = w; r1_valid = 1'b1; end
    else     begin r0_din = w; r0_valid = 1'b1; end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (req ? r1_ready : r0_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (req) r1_valid = 1'b0; else r0_valid = 1'b0;
    chk("send_grant", 32'(done), 1);
    chk("rx_strobe", 32'(ram_rx_valid), 1);
    chk("rx_word", 32'(ram_din), 32'(w));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_ram_din", 32'(ram_din), 0);
    chk("rst_rx_valid", 32'(ram_rx_valid), 0);
    chk("rst_ready", 32'({r0_ready, r1_ready}), 0);
    chk("rst_tx", 32'({r0_tx_valid, r1_tx_valid, timeout_err}), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Write transaction from r0
    watch_r1 = 1'b1;
    send(0, 10'h005);
    @(posedge clk); #1;
    chk("rx_single_pulse", 32'(ram_rx_valid), 0);
    chk("ram_din_hold", 32'(ram_din), 32'h005);
    send(0, 10'h1A7);
    watch_r1 = 1'b0;
    chk("r1_ready_quiet", 32'(r1_seen), 0);

    // Read transaction from r0
    send(0, 10'h205);
    send(0, 10'h300);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ram_tx_valid = 1'b1; ram_dout = 8'hA7;
    @(posedge clk); #1;
    ram_tx_valid = 1'b0;
    chk("rd_tx0", 32'(r0_tx_valid), 1);
    chk("rd_dout0", 32'(r0_dout), 32'hA7);
    chk("rd_tx1_quiet", 32'(r1_tx_valid), 0);
    @(posedge clk); #1;
    chk("rd_tx0_once", 32'(r0_tx_valid), 0);

    // Contention from a fresh reset: r0 first, then r1 before r0's next transaction
    do_reset();
    r0_din = 10'h011; r0_valid = 1'b1;
    r1_din = 10'h022; r1_valid = 1'b1;
    @(negedge clk);
    chk("arb_ready", 32'({r0_ready, r1_ready}), 32'b10);
    @(posedge clk); #1;
    chk("arb_word0", 32'(ram_din), 32'h011);
    r0_din = 10'h155;
    @(negedge clk);
    chk("lock_ready", 32'({r0_ready, r1_ready}), 32'b10);
    @(posedge clk); #1;
    chk("lock_word", 32'(ram_din), 32'h155);
    r0_din = 10'h033;
    @(negedge clk);
    chk("rr_ready", 32'({r0_ready, r1_ready}), 32'b01);
    @(posedge clk); #1;
    chk("rr_word", 32'(ram_din), 32'h022);
    r1_valid = 1'b0;
    send(1, 10'h1BB);
    @(negedge clk);
    chk("rr_back_r0", 32'(r0_ready), 1);
    @(posedge clk); #1;
    chk("r0_word", 32'(ram_din), 32'h033);
    r0_din = 10'h1CC;
    @(posedge clk); #1;
    chk("r0_close", 32'(ram_din), 32'h1CC);
    r0_valid = 1'b0;

    // LOCK timeout: 16 idle cycles, then a single pulse and r0 favoured
    send(1, 10'h042);
    early = 1'b0;
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      if (timeout_err) early = 1'b1;
    end
    chk("tmo_early", 32'(early), 0);
    @(posedge clk); #1;
    chk("tmo_pulse", 32'(timeout_err), 1);
    r0_din = 10'h111; r0_valid = 1'b1;
    r1_din = 10'h122; r1_valid = 1'b1;
    @(negedge clk);
    chk("tmo_ptr", 32'({r0_ready, r1_ready}), 32'b10);
    @(posedge clk); #1;
    chk("tmo_once", 32'(timeout_err), 0);
    chk("tmo_word_r0", 32'(ram_din), 32'h111);
    r0_valid = 1'b0;
    @(posedge clk); #1;
    chk("tmo_word_r1", 32'(ram_din), 32'h122);
    r1_valid = 1'b0;

    // Data arriving on the WAIT_RD expiry cycle wins
    send(0, 10'h300);
    repeat (15) begin @(posedge clk); #1; end
    ram_tx_valid = 1'b1; ram_dout = 8'h5C;
    @(posedge clk); #1;
    ram_tx_valid = 1'b0;
    chk("tie_tx0", 32'(r0_tx_valid), 1);
    chk("tie_dout0", 32'(r0_dout), 32'h5C);
    chk("tie_no_tmo", 32'(timeout_err), 0);
    @(posedge clk); #1;
    chk("tie_no_tmo_late", 32'(timeout_err), 0);
    // Stray RAM data in IDLE
    ram_tx_valid = 1'b1; ram_dout = 8'h66;
    @(posedge clk); #1;
    ram_tx_valid = 1'b0;
    chk("stray_tx", 32'({r0_tx_valid, r1_tx_valid}), 0);
    chk("stray_dout0", 32'(r0_dout), 32'h5C);

    // Reset during WAIT_RD clears everything immediately
    send(1, 10'h380);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ram", 32'({ram_rx_valid, ram_din}), 0);
    chk("arst_dout", 32'({r0_dout, r1_dout}), 0);
    chk("arst_flags", 32'({r0_tx_valid, r1_tx_valid, timeout_err}), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ram_tx_valid = 1'b1; ram_dout = 8'h77;
    @(posedge clk); #1;
    ram_tx_valid = 1'b0;
    chk("arst_no_return", 32'({r0_tx_valid, r1_tx_valid}), 0);
    send(1, 10'h209);
    send(1, 10'h300);
    @(posedge clk); #1;
    ram_tx_valid = 1'b1; ram_dout = 8'h9E;
    @(posedge clk); #1;
    ram_tx_valid = 1'b0;
    chk("post_tx1", 32'(r1_tx_valid), 1);
    chk("post_dout1", 32'(r1_dout), 32'h9E);
    chk("post_r0_quiet", 32'({r0_tx_valid, r0_dout}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares one single-port RAM command interface (10-bit command word {opcode[1:0], payload[7:0]} plus valid strobe in, 8-bit read data plus tx_valid strobe out) between two requesters: requester 0 (SPI slave side) and requester 1 (local host/test port).
- Sits between the requesters and the RAM.
- Keeps multi-word transactions atomic: an address word and its data word are never interleaved with the other requester's words.
- Arbitrates round-robin and routes read data back to the requester that owns the transaction.

Parameters:
- ADDR_SIZE, 8, payload width; command words are ADDR_SIZE+2 bits, read data is ADDR_SIZE bits.
- TIMEOUT, 16, cycles without progress in LOCK or WAIT_RD before the lock is forcibly released (>=2).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- r0_din  in  ADDR_SIZE+2  requester 0 command word
- r0_valid  in  1  requester 0 word valid
- r0_ready  out  1  requester 0 word accepted this cycle (valid&ready)
- r0_dout  out  ADDR_SIZE  read data returned to requester 0
- r0_tx_valid  out  1  one-cycle strobe, r0_dout valid
- r1_din, r1_valid, r1_ready, r1_dout, r1_tx_valid: same as requester 0, for requester 1
- ram_din  out  ADDR_SIZE+2  command word to RAM
- ram_rx_valid  out  1  one-cycle strobe, ram_din valid
- ram_dout  in  ADDR_SIZE  RAM read data
- ram_tx_valid  in  1  RAM read data valid strobe
- timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Opcodes: 00 = write address, 01 = write data, 10 = read address, 11 = read data.
- Reset (asynchronous, rst_n low):
  - state = IDLE, owner = 0, priority pointer favours requester 0, timeout counter = 0.
  - All outputs 0: ram_din, ram_rx_valid, r*_dout, r*_tx_valid, r*_ready, timeout_err.
- States: IDLE, LOCK, WAIT_RD.
- Ready signals are combinational from state/owner/valid:
  - IDLE: ready is given only to the winner among valid requesters. If both are valid, the pointer's favourite wins; if one is valid, it wins.
  - LOCK: ready = owner's valid; non-owner ready = 0.
  - WAIT_RD: both readies = 0.
- Forwarding (accepted word = valid & ready):
  - The word is registered into ram_din and ram_rx_valid pulses high on the next cycle (latency 1). Exactly one RAM strobe per accepted word.
  - ram_din holds its value when no word is accepted; ram_rx_valid is otherwise 0.
- Transitions on an accepted word (IDLE sets owner = winner):
  - Opcode 00 or 10 -> LOCK. Also applies from LOCK: re-address is allowed and the lock persists.
  - Opcode 01 -> IDLE, end of transaction.
  - Opcode 11 -> WAIT_RD.
- WAIT_RD:
  - On ram_tx_valid, ram_dout is registered into the owner's r*_dout and the owner's r*_tx_valid pulses 1 cycle later (one cycle wide). State -> IDLE, end of transaction.
  - The non-owner's dout and tx_valid are unchanged (tx_valid stays 0).
- End of transaction: the pointer is set to favour the non-owner (round-robin). A single-word 01 transaction counts as a full transaction.
- ram_tx_valid outside WAIT_RD is ignored: no routing, no state change.
- Timeout counter:
  - Cleared on every accepted word and on entry to LOCK or WAIT_RD.
  - Increments each cycle in LOCK with no accepted word, and each cycle in WAIT_RD without ram_tx_valid.
  - On reaching TIMEOUT: -> IDLE, timeout_err pulses 1 cycle, pointer flips to the non-owner, no tx_valid is generated.
- Simultaneous ram_tx_valid and timeout expiry in the same cycle: the data wins. Route it normally, no timeout_err.
- Both requesters valid in IDLE: only the winner is accepted; the loser waits with its word held, because requesters keep valid/data stable until ready.
- rst_n asserted mid-transaction: immediate return to reset values; the in-flight read returns nothing.

Test Plan:
- Reset, then r0 sends 0x005 (write address 5) then 0x1A7 (write data A7) -> ram_rx_valid pulses one cycle after each acceptance with ram_din = 0x005 and 0x1A7; r1_ready stays 0 throughout.
- r0 sends 0x205, then 0x300; bench RAM asserts ram_tx_valid with ram_dout = 0xA7 two cycles after the 0x300 strobe -> r0_dout = 0xA7, r0_tx_valid pulses once; r1_tx_valid stays 0.
- r0 and r1 both valid from IDLE with 0x011 and 0x022 -> r0 accepted first (reset pointer); after r0's 0x1xx completes, r1 is granted before r0's next 0x033.
- r1 sends 0x042 then drops valid, TIMEOUT=16 -> exactly 16 idle LOCK cycles, then timeout_err pulses once, state IDLE, and r0 is granted next.
- In WAIT_RD, ram_tx_valid arrives on the expiry cycle -> data routed to the owner, timeout_err = 0. Stray ram_tx_valid while IDLE -> no r*_tx_valid.
- rst_n pulled low during WAIT_RD -> all outputs 0 immediately; after release, a new r1 transaction completes normally.
